// File: rtl/audio_player_if.sv
// audio_player_if: playback control, sample-memory port and audio outputs of the audio player
interface audio_player_if #(parameter int DATA_W = 14, parameter int ADDR_W = 18, parameter int OUT_W = 4);
  logic start, stop, loop;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [3:0] vol;
  logic mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*DATA_W-1:0] mem_data;
  logic busy, done;
  logic [OUT_W-1:0] audio_l, audio_r;
  modport master (
    output start, stop, loop, start_addr, end_addr, vol, mem_data,
    input mem_rd, mem_addr, busy, done, audio_l, audio_r
  );
  modport slave (
    input start, stop, loop, start_addr, end_addr, vol, mem_data,
    output mem_rd, mem_addr, busy, done, audio_l, audio_r
  );
endinterface

// File: rtl/audio_player.sv
// audio_player: streams stereo samples from synchronous memory, applies volume and delta-sigma modulates
module audio_player #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 18,
  parameter int DIVIDER = 567,
  parameter int OUT_W = 4
) (
  input logic clk_25mhz,
  input logic rst,
  audio_player_if.slave bus
);
  localparam int CW = $clog2(DIVIDER);
  localparam int EW = DATA_W - OUT_W;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] cur, first_addr, last_addr;
  logic loop_r, rd_pend, rd_last, done_r;
  logic tick, go, rd, halt, capture, fin;
  assign tick = cnt == '0;
  assign go = bus.start && !bus.stop;
  assign rd = state == PLAY && tick;
  assign halt = state == PLAY && bus.stop;
  // a read still in flight is dropped by any start or stop arriving with its data
  assign capture = rd_pend && !bus.start && !bus.stop;
  assign fin = capture && rd_last;
  assign bus.mem_rd = rd;
  assign bus.mem_addr = cur;
  assign bus.busy = state == PLAY;
  assign bus.done = done_r;
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x, input logic [3:0] v);
    logic signed [DATA_W+5:0] s, p;
    s = $signed((DATA_W+6)'(x)) - $signed((DATA_W+6)'(MID));
    p = s * $signed((DATA_W+6)'(v) + (DATA_W+6)'(1));
    return DATA_W'(p >>> 4) + MID;
  endfunction
  always_ff @(posedge clk_25mhz) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = go ? PLAY : (bus.stop || fin) ? IDLE : state;
  end
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      cnt <= '0;
      cur <= '0;
      first_addr <= '0;
      last_addr <= '0;
      loop_r <= 1'b0;
      rd_pend <= 1'b0;
      rd_last <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cnt <= cnt == CW'(DIVIDER - 1) ? '0 : cnt + 1'b1;
      rd_pend <= rd && !bus.start && !bus.stop;
      rd_last <= cur == last_addr && !loop_r;
      done_r <= fin;
      if (go) begin
        cur <= bus.start_addr;
        first_addr <= bus.start_addr;
        last_addr <= bus.end_addr;
        loop_r <= bus.loop;
      end else if (rd && !bus.stop) begin
        cur <= cur != last_addr ? cur + 1'b1 : loop_r ? first_addr : cur;
      end
    end
  end
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DATA_W-1:0] smp;
    logic [EW-1:0] err;
    logic [OUT_W-1:0] aud;
    logic [DATA_W:0] sum;
    assign sum = {1'b0, smp} + {{(OUT_W+1){1'b0}}, err};
    always_ff @(posedge clk_25mhz) begin
      if (rst) begin
        smp <= MID;
        err <= '0;
        aud <= '0;
      end else begin
        smp <= halt ? MID : capture ? scale(bus.mem_data[(1-c)*DATA_W +: DATA_W], bus.vol) : smp;
        aud <= sum[DATA_W] ? '1 : sum[DATA_W-1 -: OUT_W];
        err <= sum[EW-1:0];
      end
    end
  end
  assign bus.audio_l = g_ch[0].aud;
  assign bus.audio_r = g_ch[1].aud;
endmodule

// File: tb/tb_audio_player.sv
// tb_audio_player: table and random sample checks plus playback sequences against a reference model
module tb_audio_player;
  localparam int DW = 14, AW = 18, DIV = 567, OW = 4;
  localparam int MIDV = 1 << (DW - 1);
  logic clk_25mhz = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  logic [AW-1:0] pin_addr = 18'h20000;
  logic [2*DW-1:0] pin_word = '0;
  logic [2*DW-1:0] w;
  int rd_cyc[$], dn_cyc[$];
  logic [AW-1:0] rd_adr[$];
  int lp_exp[6] = '{'h3FFFE, 'h3FFFF, 0, 1, 'h3FFFE, 'h3FFFF};
  typedef struct {
    logic [DW-1:0] l, r;
    logic [3:0] v;
    int el, er;
  } vec_t;
  vec_t tbl[6];

  audio_player_if #(.DATA_W(DW), .ADDR_W(AW), .OUT_W(OW)) bus();
  audio_player #(.DATA_W(DW), .ADDR_W(AW), .DIVIDER(DIV), .OUT_W(OW)) dut (
    .clk_25mhz(clk_25mhz),
    .rst(rst),
    .bus(bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2*DW-1:0] word_at(input logic [AW-1:0] a);
    return a == pin_addr ? pin_word : {2'b01, a[11:0], 2'b10, ~a[11:0]};
  endfunction

  always @(posedge clk_25mhz) if (bus.mem_rd) bus.mem_data <= word_at(bus.mem_addr);

  always @(negedge clk_25mhz) begin
    if (bus.mem_rd) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(bus.mem_addr);
    end
    if (bus.done) dn_cyc.push_back(cyc);
    cyc++;
  end

  function automatic int scale_m(input int x, input int v);
    int p;
    p = (x - MIDV) * (v + 1);
    return MIDV + (p >= 0 ? p / 16 : -((-p + 15) / 16));
  endfunction

  task automatic ds_step(input int x, inout int e, output int o);
    int s;
    s = x + e;
    o = s >= (1 << DW) ? (1 << OW) - 1 : s / (1 << (DW - OW));
    e = s % (1 << (DW - OW));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    tick_n(3);
    rst = 1'b0;
  endtask

  task automatic clear_logs;
    rd_cyc.delete();
    rd_adr.delete();
    dn_cyc.delete();
  endtask

  task automatic go(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic lp);
    bus.start_addr = sa;
    bus.end_addr = ea;
    bus.loop = lp;
    bus.start = 1'b1;
    tick_n(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_rd(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (bus.mem_rd) ok = 1'b1;
      else tick_n(1);
    end
  endtask

  task automatic sum_check(input string nm, input int xl, input int xr);
    int sl, sr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < (1 << (DW - OW)); i++) begin
      sl += bus.audio_l;
      sr += bus.audio_r;
      tick_n(1);
    end
    chk({nm, " sum_l"}, sl, xl);
    chk({nm, " sum_r"}, sr, xr);
  endtask

  task automatic clip_test(input string nm, input vec_t t);
    bit ok;
    int e_l, e_r, o_l, o_r, bad;
    e_l = 0;
    e_r = 0;
    bad = 0;
    do_reset;
    pin_addr = AW'(32'h100 + $urandom_range(0, 255));
    pin_word = {t.l, t.r};
    bus.vol = t.v;
    go(pin_addr, pin_addr, 1'b0);
    wait_rd(DIV + 10, ok);
    chk({nm, " read"}, int'(ok), 1);
    chk({nm, " addr"}, bus.mem_addr, pin_addr);
    tick_n(2);
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " busy"}, bus.busy, 0);
    tick_n(1);
    for (int i = 0; i < 12; i++) begin
      ds_step(t.el, e_l, o_l);
      ds_step(t.er, e_r, o_r);
      if (bus.audio_l != OW'(o_l) || bus.audio_r != OW'(o_r)) bad++;
      tick_n(1);
    end
    chk({nm, " audio cycles wrong"}, bad, 0);
  endtask

  initial begin
    bit ok;
    int bad;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.start_addr = '0;
    bus.end_addr = '0;
    bus.vol = 4'd15;
    tbl[0] = '{14'h2200, 14'h1E00, 4'd15, 'h2200, 'h1E00};
    tbl[1] = '{14'h2200, 14'h1E00, 4'd7, 'h2100, 'h1F00};
    tbl[2] = '{14'h3FFF, 14'h0000, 4'd0, 'h21FF, 'h1E00};
    tbl[3] = '{14'h3FFF, 14'h0000, 4'd15, 'h3FFF, 'h0000};
    tbl[4] = '{14'h0001, 14'h2001, 4'd3, 'h1800, 'h2000};
    tbl[5] = '{14'h1234, 14'h2ABC, 4'd8, 'h183D, 'h2609};

    do_reset;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset mem_rd", bus.mem_rd, 0);
    chk("reset audio_l", bus.audio_l, 0);
    chk("reset audio_r", bus.audio_r, 0);
    tick_n(1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.mem_rd || bus.busy || bus.audio_l != 4'd8 || bus.audio_r != 4'd8) bad++;
      tick_n(1);
    end
    chk("idle cycles wrong", bad, 0);

    for (int i = 0; i < 6; i++) clip_test($sformatf("table%0d", i), tbl[i]);
    for (int i = 0; i < 6; i++) begin
      vec_t t;
      t.l = DW'($urandom);
      t.r = DW'($urandom);
      t.v = 4'($urandom_range(0, 15));
      t.el = scale_m(int'(t.l), int'(t.v));
      t.er = scale_m(int'(t.r), int'(t.v));
      clip_test($sformatf("rand%0d", i), t);
    end
    pin_addr = 18'h20000;

    do_reset;
    bus.vol = 4'd15;
    clear_logs;
    go(18'h10, 18'h13, 1'b0);
    tick_n(4 * DIV + 100);
    chk("oneshot reads", rd_adr.size(), 4);
    for (int i = 0; i < 4 && i < rd_adr.size(); i++) begin
      chk("oneshot addr", rd_adr[i], 'h10 + i);
      if (i > 0) chk("oneshot spacing", rd_cyc[i] - rd_cyc[i-1], DIV);
    end
    chk("oneshot done count", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0 && rd_cyc.size() > 0)
      chk("oneshot done latency", dn_cyc[0] - rd_cyc[rd_cyc.size()-1], 2);
    chk("oneshot busy", bus.busy, 0);
    w = word_at(18'h13);
    sum_check("oneshot hold", int'(w[2*DW-1:DW]), int'(w[DW-1:0]));

    do_reset;
    clear_logs;
    go(18'h3FFFE, 18'h00001, 1'b1);
    tick_n(6 * DIV + 10);
    chk("loop enough reads", int'(rd_adr.size() >= 6), 1);
    for (int i = 0; i < 6 && i < rd_adr.size(); i++) chk("loop addr", rd_adr[i], lp_exp[i]);
    chk("loop done count", dn_cyc.size(), 0);
    chk("loop busy", bus.busy, 1);
    bus.stop = 1'b1;
    tick_n(1);
    bus.stop = 1'b0;
    chk("loop stop busy", bus.busy, 0);
    clear_logs;
    tick_n(DIV + 10);
    chk("loop stop reads", rd_adr.size(), 0);

    do_reset;
    clear_logs;
    go(18'h20, 18'h30, 1'b0);
    wait_rd(DIV + 10, ok);
    chk("stopstart first read", int'(ok), 1);
    tick_n(1);
    bus.start_addr = 18'h25;
    bus.end_addr = 18'h26;
    bus.stop = 1'b1;
    bus.start = 1'b1;
    tick_n(1);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk("stopstart busy", bus.busy, 0);
    clear_logs;
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      if (bus.mem_rd || bus.done || bus.audio_l != 4'd8 || bus.audio_r != 4'd8) bad++;
      tick_n(1);
    end
    chk("stopstart quiet cycles wrong", bad, 0);
    chk("stopstart reads", rd_adr.size(), 0);

    do_reset;
    clear_logs;
    go(18'h40, 18'h45, 1'b0);
    wait_rd(DIV + 10, ok);
    chk("restart first read", int'(ok), 1);
    tick_n(1);
    go(18'h50, 18'h50, 1'b0);
    bad = 0;
    for (int i = 0; i < DIV - 10; i++) begin
      if (bus.audio_l != 4'd8 || bus.audio_r != 4'd8) bad++;
      tick_n(1);
    end
    chk("restart discard cycles wrong", bad, 0);
    tick_n(30);
    chk("restart reads", rd_adr.size(), 2);
    if (rd_adr.size() == 2) begin
      chk("restart addr", rd_adr[1], 'h50);
      chk("restart spacing", rd_cyc[1] - rd_cyc[0], DIV);
    end
    chk("restart done count", dn_cyc.size(), 1);
    chk("restart busy", bus.busy, 0);
    w = word_at(18'h50);
    sum_check("restart hold", int'(w[2*DW-1:DW]), int'(w[DW-1:0]));

    do_reset;
    clear_logs;
    go(18'h60, 18'h61, 1'b0);
    wait_rd(DIV + 10, ok);
    chk("midreset first read", int'(ok), 1);
    tick_n(1);
    rst = 1'b1;
    tick_n(1);
    chk("midreset busy", bus.busy, 0);
    chk("midreset audio_l", bus.audio_l, 0);
    chk("midreset audio_r", bus.audio_r, 0);
    rst = 1'b0;
    tick_n(1);
    clear_logs;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.busy || bus.done || bus.audio_l != 4'd8 || bus.audio_r != 4'd8) bad++;
      tick_n(1);
    end
    chk("midreset quiet cycles wrong", bad, 0);
    chk("midreset reads", rd_adr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
